// File: rtl/fb_access_arbiter.sv
// fb_access_arbiter: shares one single-port synchronous frame-buffer RAM
// between the real-time VGA pixel reader and the bursty OV7670 capture writer.
// Reads win the RAM port; writes wait in a small FIFO and drain in free cycles.
// A starvation guard steals one read slot after the FIFO has been full too long.
// Optional build macro: FB_ARB_STATS_EN adds stat_stolen / stat_blocked counters.
module fb_access_arbiter #(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WFIFO_DEPTH = 8,
  parameter int unsigned STARVE_LIM  = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           rd_req,
  input  logic [ADDR_W-1:0]              rd_addr,
  output logic [DATA_W-1:0]              rd_data,
  output logic                           rd_valid,
  output logic                           rd_miss,
  input  logic                           wr_req,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [DATA_W-1:0]              wr_data,
  output logic                           wr_ready,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  output logic [$clog2(WFIFO_DEPTH):0]   wfifo_level,
  output logic                           overflow
`ifdef FB_ARB_STATS_EN
  ,
  output logic [15:0]                    stat_stolen,
  output logic [15:0]                    stat_blocked
`endif
);

  localparam int unsigned PTR_W = $clog2(WFIFO_DEPTH);
  localparam int unsigned LVL_W = $clog2(WFIFO_DEPTH) + 1;
  localparam int unsigned CNT_W = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t state;

  logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [WFIFO_DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [LVL_W-1:0]  level;
  logic [CNT_W-1:0]  starve_cnt;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic steal;
  logic miss;

  assign full        = (level == LVL_W'(WFIFO_DEPTH));
  assign empty       = (level == '0);
  assign wr_ready    = !full;
  assign wfifo_level = level;
  assign push        = reset && wr_req && !full;
  assign pop         = (state == S_WR);
  assign steal       = full && (starve_cnt == CNT_W'(STARVE_LIM));
  assign miss        = rd_req && (state != S_RD);
  assign rd_data     = rd_valid ? mem_rdata : '0;

  // Per-cycle RAM port decision: starvation steal, then reads, then FIFO drain.
  always_comb begin
    state = S_IDLE;
    if (reset) begin
      if (steal) begin
        state = S_WR;
      end else if (rd_req) begin
        state = S_RD;
      end else if (!empty) begin
        state = S_WR;
      end
    end
  end

  // RAM port drive decoded from the current decision.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_RD: begin
        mem_en   = 1'b1;
        mem_addr = rd_addr;
      end
      S_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = fifo_addr[rptr];
        mem_wdata = fifo_data[rptr];
      end
      default: begin
      end
    endcase
  end

  // Read pipeline: valid follows a granted read, miss flags a stolen slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_miss  <= 1'b0;
    end else begin
      rd_valid <= (state == S_RD);
      rd_miss  <= miss;
    end
  end

  // Write FIFO storage; entries need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wptr] <= wr_addr;
      fifo_data[wptr] <= wr_data;
    end
  end

  // Write FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Starvation counter: counts full cycles without a drain, saturating at the limit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if ((state == S_WR) || !full) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_W'(STARVE_LIM)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Sticky overflow: a write was offered while the FIFO was full.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (wr_req && full) begin
      overflow <= 1'b1;
    end
  end

`ifdef FB_ARB_STATS_EN
  // Saturating event counters for stolen read slots and blocked write cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_stolen  <= '0;
      stat_blocked <= '0;
    end else begin
      if (miss && (stat_stolen != 16'hFFFF)) begin
        stat_stolen <= stat_stolen + 16'd1;
      end
      if (wr_req && full && (stat_blocked != 16'hFFFF)) begin
        stat_blocked <= stat_blocked + 16'd1;
      end
    end
  end
`endif

endmodule
